// File: rtl/alarm_setter.sv
// Front-panel alarm controller: conditions four push-buttons, edits the alarm
// time fields, arms the alarm and drives ring/snooze/stop on a match pulse.
module alarm_setter #(
    parameter int RING_TIMEOUT  = 12,
    parameter int SNOOZE_CYCLES = 8,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    input  logic       alarm_in,
    output logic [1:0] alarm_hours,
    output logic [1:0] alarm_minutes,
    output logic [3:0] alarm_seconds,
    output logic       alarm_en,
    output logic [1:0] set_field,
    output logic       ring,
    output logic       snoozing
);

    typedef enum logic [2:0] {
        IDLE,
        SET_H,
        SET_M,
        SET_S,
        RINGING,
        SNOOZE
    } state_t;

    // Button vector order: {stop, snooze, inc, mode}
    logic [3:0] btn_raw;
    logic [3:0] btn_p0;
    logic [3:0] btn_p1;
    logic [3:0] btn_p2;
    logic [3:0] ev;

    assign btn_raw = {btn_stop, btn_snooze, btn_inc, btn_mode};

    // Stage p0/p1: two-flop synchronizer; p2: history for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            btn_p2 <= '0;
        end else begin
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    assign ev = btn_p1 & ~btn_p2;

    logic ev_mode, ev_inc, ev_snooze, ev_stop;
    assign ev_mode   = ev[0];
    assign ev_inc    = ev[1];
    assign ev_snooze = ev[2];
    assign ev_stop   = ev[3];

    state_t     state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [7:0] snz_cnt_q, snz_cnt_d;
    logic [2:0] snz_num_q, snz_num_d;
    logic [1:0] hours_d, minutes_d;
    logic [3:0] seconds_d;
    logic       en_d;
    logic [1:0] set_field_d;
    logic       ring_d, snoozing_d;

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        snz_num_d  = snz_num_q;
        hours_d    = alarm_hours;
        minutes_d  = alarm_minutes;
        seconds_d  = alarm_seconds;
        en_d       = alarm_en;

        case (state_q)
            IDLE: begin
                if (alarm_in && alarm_en) begin
                    state_d    = RINGING;
                    ring_cnt_d = 8'(RING_TIMEOUT);
                    snz_num_d  = '0;
                end else if (ev_mode) begin
                    state_d = SET_H;
                end else if (ev_inc) begin
                    en_d = ~alarm_en;
                end
            end
            SET_H: begin
                if (ev_mode)     state_d = SET_M;
                else if (ev_inc) hours_d = alarm_hours + 2'd1;
            end
            SET_M: begin
                if (ev_mode)     state_d = SET_S;
                else if (ev_inc) minutes_d = alarm_minutes + 2'd1;
            end
            SET_S: begin
                if (ev_mode)     state_d = IDLE;
                else if (ev_inc) seconds_d = alarm_seconds + 4'd1;
            end
            RINGING: begin
                if (ev_stop) begin
                    state_d = IDLE;
                end else if (ev_snooze) begin
                    if (snz_num_q < 3'(MAX_SNOOZE)) begin
                        state_d   = SNOOZE;
                        snz_num_d = snz_num_q + 3'd1;
                        snz_cnt_d = 8'(SNOOZE_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ring_cnt_d = ring_cnt_q - 8'd1;
                    if (ring_cnt_q <= 8'd1) state_d = IDLE;
                end
            end
            SNOOZE: begin
                if (ev_stop) begin
                    state_d = IDLE;
                end else begin
                    snz_cnt_d = snz_cnt_q - 8'd1;
                    if (snz_cnt_q <= 8'd1) begin
                        state_d    = RINGING;
                        ring_cnt_d = 8'(RING_TIMEOUT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Indicator outputs are decoded from the next state so they register with it
        set_field_d = 2'd0;
        ring_d      = 1'b0;
        snoozing_d  = 1'b0;
        case (state_d)
            SET_H:   set_field_d = 2'd1;
            SET_M:   set_field_d = 2'd2;
            SET_S:   set_field_d = 2'd3;
            RINGING: ring_d      = 1'b1;
            SNOOZE:  snoozing_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ring_cnt_q    <= '0;
            snz_cnt_q     <= '0;
            snz_num_q     <= '0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_seconds <= '0;
            alarm_en      <= 1'b0;
            set_field     <= '0;
            ring          <= 1'b0;
            snoozing      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_cnt_q    <= ring_cnt_d;
            snz_cnt_q     <= snz_cnt_d;
            snz_num_q     <= snz_num_d;
            alarm_hours   <= hours_d;
            alarm_minutes <= minutes_d;
            alarm_seconds <= seconds_d;
            alarm_en      <= en_d;
            set_field     <= set_field_d;
            ring          <= ring_d;
            snoozing      <= snoozing_d;
        end
    end

endmodule

// File: tb/tb_alarm_setter.sv
// Scoreboard bench for alarm_setter: a behavioural model predicts the outputs
// after every clock edge; a monitor compares them one edge at a time.
module tb_alarm_setter;

    localparam int RT = 12;
    localparam int SC = 8;
    localparam int MS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_snooze, btn_stop, alarm_in;
    logic [1:0] alarm_hours, alarm_minutes, set_field;
    logic [3:0] alarm_seconds;
    logic       alarm_en, ring, snoozing;

    always #5 clk = ~clk;

    alarm_setter #(.RING_TIMEOUT(RT), .SNOOZE_CYCLES(SC), .MAX_SNOOZE(MS)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .alarm_in(alarm_in),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_seconds(alarm_seconds),
        .alarm_en(alarm_en), .set_field(set_field), .ring(ring), .snoozing(snoozing)
    );

    typedef logic [12:0] obs_t;  // {hours, minutes, seconds, en, set_field, ring, snoozing}

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rst_req;

    // Behavioural model: mode 0 idle, 1..3 editing hours/minutes/seconds, 4 ringing, 5 snoozing
    int       m_mode, m_hrs, m_min, m_sec, m_ring_left, m_snz_left, m_snz_used;
    bit       m_en;
    bit [3:0] smp1, smp2, smp3;  // button levels sampled 1, 2 and 3 edges ago

    function automatic obs_t dut_obs();
        return {alarm_hours, alarm_minutes, alarm_seconds, alarm_en, set_field, ring, snoozing};
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_hrs = 0; m_min = 0; m_sec = 0; m_en = 1'b0;
        m_ring_left = 0; m_snz_left = 0; m_snz_used = 0;
        smp1 = '0; smp2 = '0; smp3 = '0;
    endfunction

    function automatic obs_t m_obs();
        logic [1:0] sf;
        sf = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
        return {2'(m_hrs), 2'(m_min), 4'(m_sec), m_en, sf, (m_mode == 4), (m_mode == 5)};
    endfunction

    // One clock edge: b = {stop, snooze, inc, mode} levels sampled at this edge
    function automatic void m_edge(bit [3:0] b, bit al);
        bit [3:0] ev;
        bit e_mode, e_inc, e_snz, e_stop;
        ev = smp2 & ~smp3;
        smp3 = smp2; smp2 = smp1; smp1 = b;
        e_mode = ev[0]; e_inc = ev[1]; e_snz = ev[2]; e_stop = ev[3];
        if (m_mode == 0) begin
            if (al && m_en) begin
                m_mode = 4; m_ring_left = RT; m_snz_used = 0;
            end else if (e_mode) m_mode = 1;
            else if (e_inc) m_en = !m_en;
        end else if (m_mode <= 3) begin
            if (e_mode) m_mode = (m_mode == 3) ? 0 : m_mode + 1;
            else if (e_inc) begin
                if (m_mode == 1) m_hrs = (m_hrs + 1) % 4;
                else if (m_mode == 2) m_min = (m_min + 1) % 4;
                else m_sec = (m_sec + 1) % 16;
            end
        end else if (m_mode == 4) begin
            if (e_stop) m_mode = 0;
            else if (e_snz) begin
                if (m_snz_used < MS) begin
                    m_snz_used++; m_mode = 5; m_snz_left = SC;
                end else m_mode = 0;
            end else begin
                m_ring_left--;
                if (m_ring_left == 0) m_mode = 0;
            end
        end else begin
            if (e_stop) m_mode = 0;
            else begin
                m_snz_left--;
                if (m_snz_left == 0) begin
                    m_mode = 4; m_ring_left = RT;
                end
            end
        end
    endfunction

    task automatic cyc(input bit [3:0] b, input bit al);
        @(negedge clk);
        reset = rst_req;
        {btn_stop, btn_snooze, btn_inc, btn_mode} = b;
        alarm_in = al;
        if (rst_req) m_reset();
        else m_edge(b, al);
        exp_q.push_back(m_obs());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(4'b0000, 1'b0);
    endtask

    task automatic press(input int idx);
        bit [3:0] b;
        b = '0;
        b[idx] = 1'b1;
        cyc(b, 1'b0); cyc(b, 1'b0);
        cyc(4'b0000, 1'b0); cyc(4'b0000, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        exp_q.delete();
        reset = 1'b1;
        rst_req = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (dut_obs() !== m_obs()) begin
            n_bad++;
            $display("FAIL %s: outputs %h, required %h", tag, dut_obs(), m_obs());
        end
        cyc(4'b0000, 1'b0);
        rst_req = 1'b0;
    endtask

    obs_t mon_exp, mon_act;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = dut_obs();
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL outputs @%0t: got h=%0d m=%0d s=%0d en=%0b sf=%0d ring=%0b snz=%0b, required h=%0d m=%0d s=%0d en=%0b sf=%0d ring=%0b snz=%0b",
                         $time, mon_act[12:11], mon_act[10:9], mon_act[8:5], mon_act[4], mon_act[3:2], mon_act[1], mon_act[0],
                         mon_exp[12:11], mon_exp[10:9], mon_exp[8:5], mon_exp[4], mon_exp[3:2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        bit [3:0] rb;
        reset = 1'b1; rst_req = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0; btn_stop = 1'b0; alarm_in = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if (dut_obs() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_state: outputs %h, required 0", dut_obs());
        end
        idle(2);
        rst_req = 1'b0;
        idle(2);

        // Arm, ring, then reset mid-ring; afterwards an unarmed pulse must not ring
        press(1);
        cyc(4'b0000, 1'b1);
        idle(4);
        async_reset_check("reset_mid_ring");
        idle(2);
        cyc(4'b0000, 1'b1);
        idle(3);

        // Program 2:1:14, then wrap seconds 14 -> 0
        press(0); press(1); press(1);
        press(0); press(1);
        press(0); repeat (14) press(1);
        press(0);
        press(0); press(0); press(0);
        press(1); press(1);
        press(0);

        // Arm and ring to timeout
        press(1);
        cyc(4'b0000, 1'b1);
        idle(RT + 3);

        // Three snoozes then a fourth that ends the alarm
        cyc(4'b0000, 1'b1);
        idle(2);
        repeat (4) begin
            press(2);
            idle(SC + 2);
        end
        idle(RT + 2);

        // Snooze and stop together; then alarm_in coinciding with a mode event
        cyc(4'b0000, 1'b1);
        idle(2);
        cyc(4'b1100, 1'b0); cyc(4'b1100, 1'b0);
        idle(3);
        cyc(4'b0001, 1'b0); cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b1);
        idle(3);
        press(3);
        idle(2);

        // Held inc in SET_M, and an ignored alarm pulse while editing
        press(0); press(0);
        repeat (20) cyc(4'b0010, 1'b0);
        idle(2);
        cyc(4'b0000, 1'b1);
        idle(3);
        press(0); press(0);
        idle(2);

        // Randomised traffic with one asynchronous reset in the middle
        rb = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, (k == 3) ? 14 : 5) == 0) rb[k] = ~rb[k];
            end
            cyc(rb, ($urandom_range(0, 15) == 0));
            if (i == 1500) begin
                async_reset_check("reset_random");
                rb = '0;
            end
        end
        idle(3);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_setter.md
# alarm_setter

Front-panel controller that writes the alarm-time registers consumed by the clock/alarm-match block and handles that block's single-cycle `alarm` pulse. Turns four asynchronous push-buttons into a set-mode state machine (hours, minutes, seconds edit) and an alarm-enable toggle. On a match pulse it drives a ring output, with snooze, auto-timeout and stop. It sits between the board buttons and the timekeeping core.

## Interface
- `RING_TIMEOUT`, 12: cycles `ring` stays high without a button press (1..255).
- `SNOOZE_CYCLES`, 8: cycles spent silent in snooze before re-ringing (1..255).
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event; further snooze presses act as stop (0..7).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `btn_mode`  in  1  async button: cycle set fields.
- `btn_inc`  in  1  async button: increment the field being edited / toggle enable.
- `btn_snooze`  in  1  async button: snooze.
- `btn_stop`  in  1  async button: stop ringing.
- `alarm_in`  in  1  synchronous one-cycle match pulse from the clock block.
- `alarm_hours`  out  2  programmed alarm hours.
- `alarm_minutes`  out  2  programmed alarm minutes.
- `alarm_seconds`  out  4  programmed alarm seconds.
- `alarm_en`  out  1  alarm armed.
- `set_field`  out  2  edit indicator: 0 none, 1 hours, 2 minutes, 3 seconds.
- `ring`  out  1  buzzer drive.
- `snoozing`  out  1  high in SNOOZE.

## Operation
- **Button conditioning:** each button goes through a 2-flop synchronizer plus a history flop. A press event is sync2 & ~hist, one cycle wide per low→high transition. Holding a button produces exactly one event. `alarm_in` is not synchronized.
- **States:** IDLE, SET_H, SET_M, SET_S, RINGING, SNOOZE. All outputs are registered.
- **IDLE**
  - `alarm_in` & `alarm_en` → RINGING; the ring counter loads RING_TIMEOUT and the snooze count clears.
  - Otherwise, mode → SET_H.
  - Otherwise, inc toggles `alarm_en`.
  - Snooze and stop are ignored.
- **SET_H / SET_M / SET_S**
  - Mode advances SET_H→SET_M→SET_S→IDLE.
  - Inc adds 1 to the selected field, modulo field width: hours/minutes 3→0, seconds 15→0. Inc never carries into the next field.
  - `alarm_in` is ignored; no ring while editing.
  - Snooze and stop are ignored.
  - `set_field` = 1/2/3 respectively.
- **RINGING** (`ring`=1)
  - Stop → IDLE.
  - Otherwise, snooze with count < MAX_SNOOZE → SNOOZE; the count increments and the snooze counter loads SNOOZE_CYCLES.
  - Otherwise, snooze with count == MAX_SNOOZE → IDLE.
  - Otherwise, the ring counter decrements; reaching 0 → IDLE.
  - Mode, inc and `alarm_in` are ignored.
- **SNOOZE** (`snoozing`=1)
  - Stop → IDLE.
  - Otherwise, the counter decrements; reaching 0 → RINGING with the ring counter reloaded to RING_TIMEOUT.
  - Snooze, mode, inc and `alarm_in` are ignored.
- **Priority on simultaneous events:** stop > snooze > `alarm_in` > mode > inc. Lower-priority events in the same cycle are dropped, not queued.
- **Editing while armed:** field edits take effect the cycle after the event. `alarm_en` is unchanged by set mode.
- **Reset:** asynchronous, at any time including mid-ring or mid-edit. State → IDLE; all outputs 0; all counters and synchronizer flops 0.

## Timing
- **Button latency:** a button first sampled high at edge E0 gives sync2=1 after E1. The resulting register/state change is visible after E2 (3 edges, sample edge included).
- **Pulse width:** a button must stay high ≥2 edges and low ≥2 edges between presses to register distinct events.
- **alarm_in latency:** `alarm_in` high at edge E → `ring`=1 after E. `ring` stays high for exactly RING_TIMEOUT cycles if no button is pressed, then drops.
- **Snooze to re-ring:** a snooze event acted on at edge S → `ring`=0 and `snoozing`=1 after S. `snoozing` stays high for SNOOZE_CYCLES cycles, then `ring`=1.
- **Throughput:** at most one field increment per event; no auto-repeat.

## Test plan
- Reset mid-RINGING → after reset assertion all outputs 0 with no clock edge needed; release → IDLE; a single `alarm_in` pulse with `alarm_en`=0 → `ring` stays 0.
- Program 2:1:14: mode; inc×2; mode; inc×1; mode; inc×14; mode → `alarm_hours`=2, `alarm_minutes`=1, `alarm_seconds`=14, `set_field` back to 0. Then inc×2 more in SET_S from 14 → 0 (wrap, no minute carry).
- Arm (inc in IDLE → `alarm_en`=1), pulse `alarm_in` → `ring` high 1 edge later for exactly 12 cycles, then IDLE.
- Ringing, snooze → `ring` low, `snoozing` high 8 cycles, then `ring` high again. Repeat snooze 3×; the 4th snooze → IDLE, `ring`=0.
- Snooze and stop pressed on the same edge while RINGING → IDLE, snooze count not incremented. `alarm_in` and mode together in IDLE with `alarm_en`=1 → RINGING, `set_field` stays 0.
- Hold `btn_inc` high for 20 cycles in SET_M → exactly one increment; `alarm_in` pulse during SET_M with `alarm_en`=1 → no ring.
